sha256_msg_sched: RTL

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 104 ++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// ============================================================================
// Module  : sha256_msg_sched
// Brief   : SHA-256 message schedule generator: 64 words W0..W63 per block
//           from a 16-word sliding window, streamed out with valid/ready.
//           Build option: MSG_SCHED_STALL_EN enables w_ready backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [511:0] blk_in,
    output logic         ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_valid,
    input  logic         w_ready,
    output logic         done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] c_last_idx = 6'd63;

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_idx;
    logic        r_done;
    logic        w_xfer;
    logic [31:0] w_next_word;

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

`ifdef MSG_SCHED_STALL_EN
    assign w_xfer = (r_state == RUN) & w_ready;
`else
    // Consumer is assumed always ready; every valid cycle is a transfer.
    logic w_unused_ready;
    assign w_unused_ready = w_ready;
    assign w_xfer         = (r_state == RUN);
`endif

    assign w_next_word = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 6'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < 16; i++) begin
                            r_win[i] <= blk_in[511 - 32*i -: 32];
                        end
                        r_idx   <= 6'd0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 15; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[15] <= w_next_word;
                        if (r_idx == c_last_idx) begin
                            r_idx   <= 6'd0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready   = (r_state == IDLE);
    assign w_valid = (r_state == RUN);
    assign w_out   = r_win[0];
    assign w_idx   = r_idx;
    assign done    = r_done;

endmodule

`default_nettype wire
